// File: rtl/game_input_timer.sv
// Pushbutton conditioning (synchronizer + per-button debounce FSM) and a
// run/pause game-minute clock with saturation at 255, sharing one clock.
module game_input_timer #(
    parameter int DEBOUNCE_CLKS = 1000000,
    parameter int CLKS_PER_MIN  = 100000000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [4:0] btn_raw,
    input  logic       run,
    input  logic       clear,
    output logic [4:0] btn_pulse,
    output logic [4:0] btn_level,
    output logic [7:0] minutes,
    output logic       min_tick
);

    localparam logic [23:0] DEB_LAST   = 24'(DEBOUNCE_CLKS - 1);
    localparam logic [26:0] PRESC_LAST = 27'(CLKS_PER_MIN - 1);

    typedef enum logic [1:0] {
        REL,
        PWAIT,
        HELD,
        RWAIT
    } deb_state_t;

    logic [4:0] sync_meta;
    logic [4:0] sync_q;

    // NOTE: sequential state is updated with <= so every flop samples the
    // pre-edge value of its neighbours, which is what makes the two-stage chain work.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= btn_raw;
            sync_q    <= sync_meta;
        end
    end

    genvar g;
    for (g = 0; g < 5; g++) begin : g_deb
        deb_state_t  state;
        logic [23:0] cnt;
        logic        pulse_q;
        logic        level_q;

        // NOTE: the counter is reset along with the state even though REL never
        // reads it; this keeps every button register at a known value out of reset.
        always_ff @(posedge Clk or negedge Reset) begin
            if (!Reset) begin
                state   <= REL;
                cnt     <= '0;
                pulse_q <= 1'b0;
                level_q <= 1'b0;
            end else begin
                pulse_q <= 1'b0;
                unique case (state)
                    REL: begin
                        if (sync_q[g]) begin
                            state <= PWAIT;
                            cnt   <= '0;
                        end
                    end
                    PWAIT: begin
                        if (!sync_q[g]) begin
                            state <= REL;
                        end else if (cnt == DEB_LAST) begin
                            state   <= HELD;
                            pulse_q <= 1'b1;
                            level_q <= 1'b1;
                        end else begin
                            cnt <= cnt + 24'd1;
                        end
                    end
                    HELD: begin
                        if (!sync_q[g]) begin
                            state <= RWAIT;
                            cnt   <= '0;
                        end
                    end
                    RWAIT: begin
                        // A bounce back high during release returns to HELD silently
                        if (sync_q[g]) begin
                            state <= HELD;
                        end else if (cnt == DEB_LAST) begin
                            state   <= REL;
                            level_q <= 1'b0;
                        end else begin
                            cnt <= cnt + 24'd1;
                        end
                    end
                    default: begin
                        state   <= REL;
                        level_q <= 1'b0;
                    end
                endcase
            end
        end

        assign btn_pulse[g] = pulse_q;
        assign btn_level[g] = level_q;
    end

    logic [26:0] prescaler;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            prescaler <= '0;
            minutes   <= '0;
            min_tick  <= 1'b0;
        end else begin
            min_tick <= 1'b0;
            if (clear) begin
                prescaler <= '0;
                minutes   <= '0;
            end else if (run && minutes != 8'hFF) begin
                if (prescaler == PRESC_LAST) begin
                    prescaler <= '0;
                    minutes   <= minutes + 8'd1;
                    min_tick  <= 1'b1;
                end else begin
                    prescaler <= prescaler + 27'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_game_input_timer.sv
// Bench for game_input_timer with short debounce/minute periods: a pulse
// scoreboard keyed on cycle number, plus a vector table for the game clock.
module tb_game_input_timer;

    localparam int DEB       = 4;
    localparam int CPM       = 10;
    // Input changed after negedge N is first sampled at edge N+1; the pulse is
    // then visible at negedge N+1+2+DEB.
    localparam int PRESS_LAT = 3 + DEB;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [4:0] btn_raw;
    logic       run;
    logic       clear;
    logic [4:0] btn_pulse;
    logic [4:0] btn_level;
    logic [7:0] minutes;
    logic       min_tick;

    game_input_timer #(
        .DEBOUNCE_CLKS(DEB),
        .CLKS_PER_MIN (CPM)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .btn_raw  (btn_raw),
        .run      (run),
        .clear    (clear),
        .btn_pulse(btn_pulse),
        .btn_level(btn_level),
        .minutes  (minutes),
        .min_tick (min_tick)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    typedef struct {
        int         at;
        logic [4:0] mask;
    } pulse_t;

    pulse_t sb[$];

    logic [4:0] exp_pulse;
    always @(negedge Clk) begin
        exp_pulse = '0;
        if (sb.size() > 0 && sb[0].at == cyc) begin
            exp_pulse = sb[0].mask;
            void'(sb.pop_front());
        end
        if (exp_pulse != 0 || btn_pulse != 0)
            check("btn_pulse", int'(btn_pulse), int'(exp_pulse));
    end

    int tick_count = 0;
    int tick_cycs[$];
    always @(negedge Clk) begin
        if (min_tick === 1'b1) begin
            tick_count++;
            tick_cycs.push_back(cyc);
        end
    end

    task automatic wait_cycles(int n);
        repeat (n) @(negedge Clk);
        #1;
    endtask

    task automatic press(logic [4:0] m);
        btn_raw = btn_raw | m;
        sb.push_back('{cyc + PRESS_LAT, m});
    endtask

    typedef struct {
        logic       clr;
        logic       go;
        int         cycles;
        logic [7:0] exp_min;
        int         exp_ticks;
        int         first_at;
    } tvec_t;

    tvec_t vecs[9];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int start;

        vecs[0] = '{1'b1, 1'b0, 1,    8'd0,   0,   0};
        vecs[1] = '{1'b0, 1'b1, 35,   8'd3,   3,   10};
        vecs[2] = '{1'b0, 1'b0, 20,   8'd3,   0,   0};
        vecs[3] = '{1'b0, 1'b1, 4,    8'd3,   0,   0};
        vecs[4] = '{1'b0, 1'b1, 1,    8'd4,   1,   1};
        vecs[5] = '{1'b1, 1'b0, 1,    8'd0,   0,   0};
        vecs[6] = '{1'b0, 1'b1, 2600, 8'd255, 255, 10};
        vecs[7] = '{1'b1, 1'b1, 1,    8'd0,   0,   0};
        vecs[8] = '{1'b0, 1'b1, 10,   8'd1,   1,   10};

        Reset   = 1'b0;
        btn_raw = '0;
        run     = 1'b0;
        clear   = 1'b0;
        wait_cycles(2);
        check("reset_pulse", int'(btn_pulse), 0);
        check("reset_level", int'(btn_level), 0);
        check("reset_minutes", int'(minutes), 0);
        check("reset_tick", int'(min_tick), 0);
        Reset = 1'b1;
        wait_cycles(2);

        // Clean press of BtnC held 20 cycles
        press(5'b00001);
        wait_cycles(DEB + 2);
        check("press_level_early", int'(btn_level[0]), 0);
        wait_cycles(1);
        check("press_level_on", int'(btn_level[0]), 1);
        wait_cycles(13);
        btn_raw[0] = 1'b0;
        wait_cycles(DEB + 2);
        check("release_level_held", int'(btn_level[0]), 1);
        wait_cycles(1);
        check("release_level_off", int'(btn_level[0]), 0);
        wait_cycles(4);

        // Bouncing BtnL: high/low every 2 cycles never settles long enough
        for (int k = 0; k < 10; k++) begin
            btn_raw[2] = (k % 2 == 0);
            wait_cycles(2);
            check("bounce_level", int'(btn_level[2]), 0);
        end
        btn_raw[2] = 1'b0;
        wait_cycles(8);
        check("bounce_level_end", int'(btn_level[2]), 0);

        // BtnU and BtnC pressed together
        press(5'b10001);
        wait_cycles(10);
        check("simul_level", int'(btn_level), 5'b10001);
        btn_raw = '0;
        wait_cycles(10);
        check("simul_level_off", int'(btn_level), 0);

        // Game clock vector table
        foreach (vecs[v]) begin
            clear = vecs[v].clr;
            run   = vecs[v].go;
            tick_count = 0;
            tick_cycs.delete();
            start = cyc;
            wait_cycles(vecs[v].cycles);
            check($sformatf("v%0d_minutes", v), int'(minutes), int'(vecs[v].exp_min));
            check($sformatf("v%0d_ticks", v), tick_count, vecs[v].exp_ticks);
            if (vecs[v].first_at > 0 && tick_cycs.size() > 0) begin
                check($sformatf("v%0d_first_tick", v), tick_cycs[0] - start, vecs[v].first_at);
                for (int i = 1; i < tick_cycs.size(); i++)
                    check($sformatf("v%0d_tick_spacing", v), tick_cycs[i] - tick_cycs[i-1], CPM);
            end
        end
        clear = 1'b0;
        run   = 1'b0;

        // Asynchronous reset with the clock running and BtnL held
        clear = 1'b1;
        wait_cycles(1);
        clear = 1'b0;
        run   = 1'b1;
        press(5'b00100);
        wait_cycles(70);
        check("pre_reset_minutes", int'(minutes), 7);
        check("pre_reset_level", int'(btn_level), 5'b00100);
        run   = 1'b0;
        Reset = 1'b0;
        #1;
        check("async_reset_minutes", int'(minutes), 0);
        check("async_reset_level", int'(btn_level), 0);
        check("async_reset_pulse", int'(btn_pulse), 0);
        check("async_reset_tick", int'(min_tick), 0);
        wait_cycles(2);
        Reset = 1'b1;
        sb.push_back('{cyc + PRESS_LAT, 5'b00100});
        wait_cycles(PRESS_LAT - 1);
        check("post_reset_level_early", int'(btn_level[2]), 0);
        wait_cycles(1);
        check("post_reset_level_on", int'(btn_level[2]), 1);
        btn_raw = '0;
        wait_cycles(10);

        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
